// File: rtl/tmod_pkg.sv
// ---------------------------------------------------------------------------
// tmod_pkg
// Shared definitions for the temperature-module command path: bus op and
// status encodings, the command arbiter state type and its default timeout.
// ---------------------------------------------------------------------------
package tmod_pkg;

   // Bus op 0 means "no command"; any non-zero op is a one-cycle command.
   localparam logic [3:0] OP_NOP     = 4'h0;

   // Status returned for illegal ops and for slave timeouts.
   localparam logic [1:0] STATUS_ERR = 2'b11;

   // Default number of cycles the arbiter waits for a slave answer.
   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/tmod_rr_pick.sv
// ---------------------------------------------------------------------------
// tmod_rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting one position after last_grant, wrapping around, and reports the
// first set bit.
//
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  IW     index granted most recently
//   gnt        out N_REQ  one-hot grant (all zero when no request)
//   idx        out IW     index of the granted requester
//   any        out 1      at least one request is set
// ---------------------------------------------------------------------------
module tmod_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   always_comb begin
      int          cand;
      logic [IW-1:0] cand_idx;
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Offset 1..N_REQ visits every requester once, last_grant itself last.
      for (int off = 1; off <= N_REQ; off++) begin
         cand     = (int'(last_grant) + off) % N_REQ;
         cand_idx = cand[IW-1:0];
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            idx           = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tmod_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tmod_cmd_arbiter
// Round-robin arbiter that shares one temperature-module bus slave between
// N_REQ requesters. One command is in flight at a time: grant in IDLE, drive
// the bus for one cycle in ISSUE, wait for the slave status (with timeout) in
// WAIT, and return the status to the granted requester in RESP.
//
// Handshake: a requester holds req_valid (with its req_op/req_opnd) until it
// sees req_ready for its bit; the command is taken on the rising edge where
// req_valid & req_ready are both high. req_ready is combinational and only
// ever high in IDLE with bus_ready=1. rsp_valid is a one-cycle strobe with no
// back-pressure.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/op/opnd     per-requester command (op at [4i+3:4i], opnd [8i+7:8i])
//   req_ready             one-hot accept pulse
//   rsp_valid/rsp_status  one-hot response strobe and its status
//   busy                  arbiter not in IDLE
//   bus_op/bus_opnd       master side of the tmod bus
//   bus_status/bus_valid  slave answer
//   bus_ready             slave can accept a command
//   dbg_state             current FSM state
// ---------------------------------------------------------------------------
module tmod_cmd_arbiter
   import tmod_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [4*N_REQ-1:0]   req_op,
   input  logic [8*N_REQ-1:0]   req_opnd,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [1:0]           rsp_status,
   output logic                 busy,
   output logic [3:0]           bus_op,
   output logic [7:0]           bus_opnd,
   input  logic [1:0]           bus_status,
   input  logic                 bus_valid,
   input  logic                 bus_ready,
   output arb_state_t           dbg_state
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    last_q, last_d;
   logic [3:0]       op_q, op_d;
   logic [7:0]       opnd_q, opnd_d;
   logic [1:0]       stat_q, stat_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [3:0]       bus_op_q, bus_op_d;
   logic [7:0]       bus_opnd_q, bus_opnd_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] pick_gnt;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic             grant_en;

   tmod_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_q),
      .gnt        (pick_gnt),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   // Gating with reset keeps req_ready low while reset is asserted, even
   // though the FSM already sits in IDLE.
   assign grant_en  = (state_q == IDLE) && bus_ready && pick_any && reset;
   assign req_ready = grant_en ? pick_gnt : '0;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_q       <= IW'(N_REQ - 1);
         op_q         <= OP_NOP;
         opnd_q       <= '0;
         stat_q       <= '0;
         cnt_q        <= '0;
         bus_op_q     <= OP_NOP;
         bus_opnd_q   <= '0;
         rsp_valid_q  <= '0;
         rsp_status_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         op_q         <= op_d;
         opnd_q       <= opnd_d;
         stat_q       <= stat_d;
         cnt_q        <= cnt_d;
         bus_op_q     <= bus_op_d;
         bus_opnd_q   <= bus_opnd_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      stat_d  = stat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               last_d = pick_idx;
               op_d   = req_op[{pick_idx, 2'b00} +: 4];
               opnd_d = req_opnd[{pick_idx, 3'b000} +: 8];
               // An op of 0 would be invisible on the bus, so answer it locally.
               if (op_d == OP_NOP) begin
                  stat_d  = STATUS_ERR;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Saturating count: never wraps back to 0.
            cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            // bus_valid is tested first so it wins over a same-cycle timeout.
            if (bus_valid) begin
               stat_d  = bus_status;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               stat_d  = STATUS_ERR;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: computed from the next state so the registered outputs
   // line up with the cycle the FSM is in.
   always_comb begin
      bus_op_d     = OP_NOP;
      bus_opnd_d   = '0;
      rsp_valid_d  = '0;
      rsp_status_d = '0;
      busy_d       = (state_d != IDLE);
      if (state_d == ISSUE) begin
         bus_op_d   = op_d;
         bus_opnd_d = opnd_d;
      end
      if (state_d == RESP) begin
         rsp_valid_d  = {{(N_REQ-1){1'b0}}, 1'b1} << last_d;
         rsp_status_d = stat_d;
      end
   end

   assign bus_op     = bus_op_q;
   assign bus_opnd   = bus_opnd_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_tmod_cmd_arbiter.sv
module tb_tmod_cmd_arbiter;
   import tmod_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [N-1:0]   req_valid;
   logic [4*N-1:0] req_op;
   logic [8*N-1:0] req_opnd;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [1:0]     rsp_status;
   logic           busy;
   logic [3:0]     bus_op;
   logic [7:0]     bus_opnd;
   logic [1:0]     bus_status;
   logic           bus_valid;
   logic           bus_ready;
   arb_state_t     dbg_state;

   tmod_cmd_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_opnd   (req_opnd),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_status (rsp_status),
      .busy       (busy),
      .bus_op     (bus_op),
      .bus_opnd   (bus_opnd),
      .bus_status (bus_status),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .dbg_state  (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic [5:0] exp_q[$];      // {one-hot requester, status}
   logic [5:0] exp_w, got_w;

   function automatic logic [1:0] slave_fn(input logic [3:0] op);
      return op[1:0] ^ 2'b10;
   endfunction

   function automatic logic [3:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] opnd);
      req_op[4*i +: 4]   = op;
      req_opnd[8*i +: 8] = opnd;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < 80) begin
         tick();
         n++;
      end
      chk("wait_idle_busy", busy, 0);
      chk("wait_idle_drain", exp_q.size(), 0);
   endtask

   // ---------------- bus slave model ----------------
   // Answers a command slave_delay cycles after the bus_op cycle
   // (slave_delay = 0: never answers).
   int         slave_delay = 1;
   int         slave_cnt   = 0;
   logic [1:0] slave_stat  = 2'b00;

   initial begin : slave
      bus_valid  = 1'b0;
      bus_status = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         bus_valid  = 1'b0;
         bus_status = 2'b00;
         if (slave_cnt > 0) begin
            slave_cnt--;
            if (slave_cnt == 0) begin
               bus_valid  = 1'b1;
               bus_status = slave_stat;
            end
         end
         if (bus_op != 4'h0 && slave_delay > 0) begin
            slave_cnt  = slave_delay;
            slave_stat = slave_fn(bus_op);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rsp_valid !== 4'b0000) begin
         got_w = {rsp_valid, rsp_status};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rsp_unexpected: observed %0h expected none", got_w);
         end else begin
            exp_w = exp_q.pop_front();
            checks++;
            assert (got_w === exp_w) else begin
               errors++;
               $error("FAIL rsp_scoreboard: observed %0h expected %0h", got_w, exp_w);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: observed no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin : main
      int n;
      int t0;
      reset     = 1'b0;
      req_valid = 4'hF;
      req_op    = '0;
      req_opnd  = '0;
      bus_ready = 1'b1;

      // Reset values (requests pending must not be accepted during reset)
      repeat (3) tick();
      chk("rst_bus_op", bus_op, 0);
      chk("rst_bus_opnd", bus_opnd, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_status", rsp_status, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, IDLE);
      req_valid = '0;
      reset     = 1'b1;
      tick();

      // Single request: requester 0, op 3, opnd 5A, status 01 at T+3
      slave_delay = 2;
      set_req(0, 4'h3, 8'h5A);
      req_valid = 4'b0001;
      #1;
      chk("single_ready", req_ready, 4'b0001);
      exp_q.push_back({4'b0001, 2'b01});
      tick();
      req_valid = '0;
      chk("single_bus_op", bus_op, 4'h3);
      chk("single_bus_opnd", bus_opnd, 8'h5A);
      chk("single_busy", busy, 1);
      tick();
      chk("single_bus_op_once", bus_op, 0);
      tick();
      chk("single_no_early_rsp", rsp_valid, 0);
      tick();
      chk("single_rsp_valid", rsp_valid, 4'b0001);
      chk("single_rsp_status", rsp_status, 2'b01);
      tick();
      chk("single_idle", busy, 0);
      chk("single_rsp_once", rsp_valid, 0);

      // Illegal op: requester 2 with op 0, answered at T+1 without bus traffic
      set_req(2, 4'h0, 8'hAA);
      req_valid = 4'b0100;
      #1;
      chk("illegal_ready", req_ready, 4'b0100);
      exp_q.push_back({4'b0100, STATUS_ERR});
      tick();
      req_valid = '0;
      chk("illegal_rsp_t1", rsp_valid, 4'b0100);
      chk("illegal_status", rsp_status, 2'b11);
      chk("illegal_bus_op", bus_op, 0);
      tick();
      chk("illegal_idle", busy, 0);
      chk("illegal_bus_op_after", bus_op, 0);

      // Stall: bus_ready low for 5 cycles, then grant
      set_req(1, 4'h6, 8'h33);
      req_valid = 4'b0010;
      bus_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ready", req_ready, 0);
         chk("stall_busy", busy, 0);
         tick();
      end
      bus_ready = 1'b1;
      #1;
      chk("stall_grant", req_ready, 4'b0010);
      exp_q.push_back({4'b0010, slave_fn(4'h6)});
      tick();
      req_valid = '0;
      chk("stall_bus_op", bus_op, 4'h6);
      chk("stall_bus_opnd", bus_opnd, 8'h33);
      wait_idle();

      // Timeout: slave answers only in the RESP cycle, which must be ignored
      slave_delay = TO + 1;
      set_req(3, 4'h7, 8'h77);
      req_valid = 4'b1000;
      #1;
      chk("to_ready", req_ready, 4'b1000);
      exp_q.push_back({4'b1000, STATUS_ERR});
      t0 = cyc;
      tick();
      req_valid = '0;
      n = 0;
      while (rsp_valid === 4'b0000 && n < 60) begin
         tick();
         n++;
      end
      chk("to_latency", cyc - t0, TO + 2);
      chk("to_status", rsp_status, 2'b11);
      tick();

      // Next request after a timeout is granted normally, earliest latency
      slave_delay = 1;
      set_req(0, 4'hA, 8'h01);
      req_valid = 4'b0001;
      #1;
      chk("after_to_ready", req_ready, 4'b0001);
      exp_q.push_back({4'b0001, slave_fn(4'hA)});
      t0 = cyc;
      tick();
      req_valid = '0;
      n = 0;
      while (rsp_valid === 4'b0000 && n < 60) begin
         tick();
         n++;
      end
      chk("after_to_latency", cyc - t0, 3);
      tick();

      // Collision: bus_valid on the timeout cycle returns the real status
      slave_delay = TO;
      set_req(1, 4'hB, 8'hC3);
      req_valid = 4'b0010;
      #1;
      chk("coll_ready", req_ready, 4'b0010);
      exp_q.push_back({4'b0010, slave_fn(4'hB)});
      t0 = cyc;
      tick();
      req_valid = '0;
      n = 0;
      while (rsp_valid === 4'b0000 && n < 60) begin
         tick();
         n++;
      end
      chk("coll_latency", cyc - t0, TO + 2);
      chk("coll_status", rsp_status, 2'b01);
      tick();

      // Reset while in WAIT: command dropped, no response
      slave_delay = 0;
      set_req(2, 4'h1, 8'h44);
      req_valid = 4'b0100;
      #1;
      chk("rw_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("rw_state_wait", dbg_state, WAIT);
      chk("rw_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("rw_bus_op", bus_op, 0);
      chk("rw_bus_opnd", bus_opnd, 0);
      chk("rw_rsp_valid", rsp_valid, 0);
      chk("rw_rsp_status", rsp_status, 0);
      chk("rw_busy_clr", busy, 0);
      chk("rw_req_ready", req_ready, 0);
      chk("rw_state_idle", dbg_state, IDLE);
      tick();
      chk("rw_no_rsp", rsp_valid, 0);
      tick();

      // Round-robin after reset release: grants 0,1,2,3,0 with ops 1..4
      slave_delay = 1;
      for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 8'(8'h10 + i));
      req_valid = 4'hF;
      reset     = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (req_ready === 4'b0000 && n < 40) begin
            tick();
            n++;
         end
         chk("rr_grant", req_ready, oh(k % N));
         exp_q.push_back({oh(k % N), slave_fn(4'(k % N + 1))});
         tick();
         chk("rr_bus_op", bus_op, k % N + 1);
      end
      req_valid = '0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmod_cmd_arbiter.md
# tmod_cmd_arbiter

Round-robin command arbiter sharing one temperature-module bus slave between N_REQ requesters. Each requester presents an op/operand pair; the arbiter grants one requester at a time and issues the command onto the bus as master. It waits for the slave's status, with a timeout, and routes the status back to the granted requester. It sits between the monitor's control clients (sampler, alarm logic, host regs) and the single temperature-module slave.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 16: max cycles spent in WAIT before the arbiter aborts, ≥2.

- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  N_REQ  per-requester command pending; held until accepted.
- req_op  in  4*N_REQ  op for requester i at [4i+3:4i].
- req_opnd  in  8*N_REQ  operand for requester i at [8i+7:8i].
- req_ready  out  N_REQ  one-hot accept pulse (combinational).
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- rsp_status  out  2  status returned with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- bus_op  out  4  tmod bus op (master side).
- bus_opnd  out  8  tmod bus operand.
- bus_status  in  2  slave status.
- bus_valid  in  1  slave status valid.
- bus_ready  in  1  slave can accept a command.

## Operation
- Bus protocol: op 4'h0 is NOP/idle. A command is exactly one cycle of non-zero bus_op. The slave answers with a bus_valid pulse carrying bus_status, no earlier than the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - bus_op=0.
  - If bus_ready=1 and any req_valid, the round-robin winner g is the first set bit searching from last_grant+1 with wrap.
  - req_ready[g]=1 in that same cycle.
  - On the edge, op/opnd of g are latched, last_grant=g, and the FSM goes to ISSUE.
  - If bus_ready=0, there is no grant and req_ready=0.
- Illegal op: if the winner's req_op==0, it is still accepted but skips the bus. Next state is RESP with status 2'b11.
- ISSUE: bus_op/bus_opnd drive the latched command for exactly one cycle, then WAIT. The timeout counter is cleared.
- WAIT:
  - bus_op=0; counter increments each cycle.
  - bus_valid=1 captures bus_status and goes to RESP.
  - If counter reaches TIMEOUT-1 without bus_valid, the arbiter goes to RESP with status 2'b11.
  - bus_valid and timeout in the same cycle: bus_valid wins and the real status is returned.
- RESP: rsp_valid[g]=1 and rsp_status=captured value for one cycle, then IDLE.
- bus_valid in IDLE, ISSUE or RESP is ignored.
- Counter width is $clog2(TIMEOUT+1) and the counter never wraps.
- A requester whose req_valid drops before acceptance simply loses its turn. No state is kept per requester except last_grant.

## Timing
- Reset values:
  - bus_op=0, bus_opnd=0.
  - req_ready=0, rsp_valid=0, rsp_status=0, busy=0.
  - State IDLE, last_grant=N_REQ-1, so requester 0 wins first.
- Reset mid-operation: the in-flight command is dropped and no rsp_valid is issued.
- Latency: handshake at cycle T, bus_op at T+1, earliest bus_valid at T+2, rsp_valid at T+3.
- Timeout response: rsp_valid at T+2+TIMEOUT.
- Throughput: at most one command in flight. With continuous demand, the next grant is possible in the cycle after RESP.
- Fairness: each requester with req_valid held is granted within N_REQ commands.
- All outputs are registered except req_ready, which is a function of state, bus_ready, req_valid and last_grant.

## Structure
- Shared package tmod_pkg holds:
  - OP_NOP=4'h0.
  - STATUS_ERR=2'b11.
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Default TIMEOUT.
- One sub-module, tmod_rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, index, any.
  - Reused by other monitor arbiters.
- Top-level bus ports map one-to-one onto the tmod bus Master modport signals.

## Test plan
- Single request: req_valid[0], op=4'h3, opnd=8'h5A. Expect req_ready[0] at T; bus_op=3, bus_opnd=5A at T+1 only. Slave returns status 2'b01 at T+3; expect rsp_valid[0] and rsp_status=01 at T+4.
- Round-robin: all four req_valid held with ops 1..4. Expect grants in order 0,1,2,3,0 and each requester's status returned on its own rsp_valid bit.
- Timeout: slave never asserts bus_valid, TIMEOUT=16. Expect rsp_status=2'b11 exactly 16 cycles after ISSUE; then the next request is granted normally.
- Boundaries:
  - Illegal op: req_op=0 gives no non-zero bus_op and rsp_status=11 at T+1.
  - Stall: bus_ready=0 holds req_ready=0 for 5 cycles, then grants.
  - Collision: bus_valid on the timeout cycle returns the slave status.
- Reset: assert reset in WAIT. Expect all outputs 0 immediately with no rsp_valid. After release, requester 0 wins first.
